// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the writeback stage
package core_pkg;

  localparam int XLEN = 32;

  // Register-file write source selected in writeback
  typedef enum logic [2:0] {
    RES_ALU  = 3'd0,
    RES_LOAD = 3'd1,
    RES_PC4  = 3'd2,
    RES_IMM  = 3'd3,
    RES_CREG = 3'd4,
    RES_IN   = 3'd5
  } result_src_e;

  // Load access size and extension
  typedef enum logic [1:0] {
    BYTES_WORD = 2'b00,
    BYTES_SB   = 2'b01,
    BYTES_SH   = 2'b10,
    BYTES_UB   = 2'b11
  } result_bytes_e;

  // Input-instruction handshake states
  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_WRITE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - sub-word load select and sign/zero extension
module load_extract #(
  parameter int XLEN = core_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  output logic [XLEN-1:0] ext
);
  import core_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half; a misaligned half just uses offset[1]
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
    case (size)
      BYTES_WORD: ext = word;
      BYTES_SB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      BYTES_SH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      BYTES_UB:   ext = {{(XLEN-8){1'b0}}, byte_sel};
      default:    ext = word;
    endcase
  end

endmodule

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - MEM/WB register, result select, input handshake, instret
module mem_writeback #(
  parameter int XLEN    = core_pkg::XLEN,
  parameter int RADDR_W = 6,
  parameter int CNT_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_m,
  input  logic               reg_write_m,
  input  logic [2:0]         result_src_m,
  input  logic [1:0]         result_bytes_m,
  input  logic [XLEN-1:0]    alu_result_m,
  input  logic [XLEN-1:0]    read_data_m,
  input  logic [RADDR_W-1:0] rd_m,
  input  logic [XLEN-1:0]    imm_ext_m,
  input  logic [XLEN-1:0]    pc_plus4_m,
  input  logic [XLEN-1:0]    c_reg_data_m,
  input  logic               stall_w,
  input  logic               flush_w,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               io_stall,
  output logic               reg_write_w,
  output logic [RADDR_W-1:0] rd_w,
  output logic [XLEN-1:0]    result_w,
  output logic [CNT_W-1:0]   instret
);
  import core_pkg::*;

  logic               valid_q, valid_d, reg_write_q, reg_write_d;
  logic [2:0]         result_src_q, result_src_d;
  logic [1:0]         result_bytes_q, result_bytes_d;
  logic [XLEN-1:0]    alu_result_q, alu_result_d, read_data_q, read_data_d;
  logic [XLEN-1:0]    imm_ext_q, imm_ext_d, pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0]    c_reg_data_q, c_reg_data_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  wb_state_e          state_q, state_d;
  logic [7:0]         in_buf_q, in_buf_d;
  logic               in_ready_q, in_ready_d, io_stall_q, io_stall_d;
  logic               retired_q, retired_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               load_en, in_pending, pending_d, retire_now;
  logic [XLEN-1:0]    load_val;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .word   (read_data_q),
    .offset (alu_result_q[1:0]),
    .size   (result_bytes_q),
    .ext    (load_val)
  );

  // Next MEM/WB contents: the handshake stall wins over stall_w, which wins over flush_w
  always_comb begin
    load_en        = !io_stall_q && !stall_w;
    valid_d        = valid_q;
    reg_write_d    = reg_write_q;
    result_src_d   = result_src_q;
    result_bytes_d = result_bytes_q;
    alu_result_d   = alu_result_q;
    read_data_d    = read_data_q;
    rd_d           = rd_q;
    imm_ext_d      = imm_ext_q;
    pc_plus4_d     = pc_plus4_q;
    c_reg_data_d   = c_reg_data_q;
    if (load_en) begin
      valid_d        = valid_m && !flush_w;
      reg_write_d    = reg_write_m && !flush_w;
      result_src_d   = result_src_m;
      result_bytes_d = result_bytes_m;
      alu_result_d   = alu_result_m;
      read_data_d    = read_data_m;
      rd_d           = rd_m;
      imm_ext_d      = imm_ext_m;
      pc_plus4_d     = pc_plus4_m;
      c_reg_data_d   = c_reg_data_m;
    end
  end

  // Retirement and handshake next-state; outputs are precomputed from next-state values
  always_comb begin
    in_pending = valid_q && (result_src_q == RES_IN) && !retired_q;
    retire_now = valid_q && !retired_q &&
                 ((result_src_q != RES_IN) || (state_q == WB_WRITE));
    retired_d  = load_en ? 1'b0 : (retired_q || retire_now);
    instret_d  = retire_now ? instret_q + CNT_W'(1) : instret_q;
    state_d    = state_q;
    in_buf_d   = in_buf_q;
    case (state_q)
      WB_IDLE: begin
        if (in_pending) begin
          if (in_valid) begin
            in_buf_d = in_data;
            state_d  = WB_WRITE;
          end else begin
            state_d  = WB_WAIT;
          end
        end
      end
      WB_WAIT: begin
        if (in_valid) begin
          in_buf_d = in_data;
          state_d  = WB_WRITE;
        end
      end
      WB_WRITE: state_d = WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
    pending_d  = valid_d && (result_src_d == RES_IN) && !retired_d;
    in_ready_d = ((state_d == WB_IDLE) && pending_d) || (state_d == WB_WAIT);
    io_stall_d = in_ready_d || (state_d == WB_WRITE);
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      result_src_q   <= '0;
      result_bytes_q <= '0;
      alu_result_q   <= '0;
      read_data_q    <= '0;
      rd_q           <= '0;
      imm_ext_q      <= '0;
      pc_plus4_q     <= '0;
      c_reg_data_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      result_src_q   <= result_src_d;
      result_bytes_q <= result_bytes_d;
      alu_result_q   <= alu_result_d;
      read_data_q    <= read_data_d;
      rd_q           <= rd_d;
      imm_ext_q      <= imm_ext_d;
      pc_plus4_q     <= pc_plus4_d;
      c_reg_data_q   <= c_reg_data_d;
    end
  end

  // Input handshake FSM with registered in_ready/io_stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WB_IDLE;
      in_buf_q   <= '0;
      in_ready_q <= 1'b0;
      io_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_buf_q   <= in_buf_d;
      in_ready_q <= in_ready_d;
      io_stall_q <= io_stall_d;
    end
  end

  // Retired flag and instret counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= 1'b0;
      instret_q <= '0;
    end else begin
      retired_q <= retired_d;
      instret_q <= instret_d;
    end
  end

  // Write-data select from the W register
  always_comb begin
    case (result_src_q)
      RES_ALU:  result_w = alu_result_q;
      RES_LOAD: result_w = load_val;
      RES_PC4:  result_w = pc_plus4_q;
      RES_IMM:  result_w = imm_ext_q;
      RES_CREG: result_w = c_reg_data_q;
      RES_IN:   result_w = {{(XLEN-8){1'b0}}, in_buf_q};
      default:  result_w = '0;
    endcase
  end

  assign reg_write_w = valid_q && reg_write_q && (rd_q != '0) &&
                       ((result_src_q == RES_IN) ? (state_q == WB_WRITE) : 1'b1);
  assign rd_w        = rd_q;
  assign in_ready    = in_ready_q;
  assign io_stall    = io_stall_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_mem_writeback.sv
// tb/tb_mem_writeback.sv - directed self-checking bench for mem_writeback
module tb_mem_writeback;
  localparam int XLEN = 32;
  localparam int RADDR_W = 6;
  localparam int CNT_W = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_m, reg_write_m;
  logic [2:0]         result_src_m;
  logic [1:0]         result_bytes_m;
  logic [XLEN-1:0]    alu_result_m, read_data_m, imm_ext_m, pc_plus4_m, c_reg_data_m;
  logic [RADDR_W-1:0] rd_m;
  logic               stall_w, flush_w;
  logic [7:0]         in_data;
  logic               in_valid, in_ready, io_stall, reg_write_w;
  logic [RADDR_W-1:0] rd_w;
  logic [XLEN-1:0]    result_w;
  logic [CNT_W-1:0]   instret;

  int vectors = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] exp_instret = '0;

  mem_writeback #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .result_src_m(result_src_m), .result_bytes_m(result_bytes_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m), .rd_m(rd_m),
    .imm_ext_m(imm_ext_m), .pc_plus4_m(pc_plus4_m), .c_reg_data_m(c_reg_data_m),
    .stall_w(stall_w), .flush_w(flush_w), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .io_stall(io_stall), .reg_write_w(reg_write_w),
    .rd_w(rd_w), .result_w(result_w), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_idle();
    valid_m = 1'b0; reg_write_m = 1'b0; result_src_m = 3'd0; result_bytes_m = 2'd0;
    alu_result_m = '0; read_data_m = '0; rd_m = '0;
    imm_ext_m = '0; pc_plus4_m = '0; c_reg_data_m = '0;
  endtask

  task automatic m_issue(input logic [2:0] src, input logic [1:0] bytes,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [5:0] rd);
    valid_m = 1'b1; reg_write_m = 1'b1; result_src_m = src; result_bytes_m = bytes;
    alu_result_m = alu; read_data_m = rdata; rd_m = rd;
    pc_plus4_m = 32'h0000_0104; imm_ext_m = 32'hFFFF_F800; c_reg_data_m = 32'h0000_0300;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_idle(); stall_w = 1'b0; flush_w = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step(); step();
    vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL reset_io_stall: got %b expected 0", io_stall); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    vectors++; if (reg_write_w !== 1'b0) begin miscompares++; $display("FAIL reset_reg_write_w: got %b expected 0", reg_write_w); end
    vectors++; if (rd_w !== 6'd0) begin miscompares++; $display("FAIL reset_rd_w: got %0d expected 0", rd_w); end
    vectors++; if (result_w !== 32'h0) begin miscompares++; $display("FAIL reset_result_w: got %h expected 0", result_w); end
    vectors++; if (instret !== 64'd0) begin miscompares++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    m_issue(3'd0, 2'd0, 32'h0000_1234, 32'h0, 6'd5);
    step(); m_idle();
    vectors++; if (reg_write_w !== 1'b1) begin miscompares++; $display("FAIL alu_reg_write_w: got %b expected 1", reg_write_w); end
    vectors++; if (rd_w !== 6'd5) begin miscompares++; $display("FAIL alu_rd_w: got %0d expected 5", rd_w); end
    vectors++; if (result_w !== 32'h0000_1234) begin miscompares++; $display("FAIL alu_result_w: got %h expected 00001234", result_w); end
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL alu_instret_before: got %0d expected %0d", instret, exp_instret); end
    step(); exp_instret++;
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL alu_instret_after: got %0d expected %0d", instret, exp_instret); end
    vectors++; if (reg_write_w !== 1'b0) begin miscompares++; $display("FAIL alu_bubble_reg_write_w: got %b expected 0", reg_write_w); end
  endtask

  task automatic test_result_sel();
    logic [2:0]  src [5] = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    logic [31:0] exp [5] = '{32'h0000_0104, 32'hFFFF_F800, 32'h0000_0300, 32'h0, 32'h0};
    m_issue(src[0], 2'd0, 32'hAAAA_5555, 32'h1111_2222, 6'd8);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 4) m_issue(src[i+1], 2'd0, 32'hAAAA_5555, 32'h1111_2222, 6'd8);
      else m_idle();
      vectors++; if (result_w !== exp[i]) begin miscompares++; $display("FAIL result_sel_src%0d: got %h expected %h", src[i], result_w, exp[i]); end
    end
    step(); exp_instret += 5;
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL result_sel_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_load();
    logic [1:0]  lb [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [31:0] lo [4] = '{32'd3, 32'd1, 32'd2, 32'd2};
    logic [31:0] le [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h80FF_7F01};
    m_issue(3'd1, lb[0], lo[0], 32'h80FF_7F01, 6'd7);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) m_issue(3'd1, lb[i+1], lo[i+1], 32'h80FF_7F01, 6'd7);
      else m_idle();
      vectors++; if (result_w !== le[i]) begin miscompares++; $display("FAIL load_%0d: got %h expected %h", i, result_w, le[i]); end
      vectors++; if (reg_write_w !== 1'b1) begin miscompares++; $display("FAIL load_%0d_reg_write_w: got %b expected 1", i, reg_write_w); end
    end
    step(); exp_instret += 4;
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL load_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_stall();
    m_issue(3'd0, 2'd0, 32'h0000_0055, 32'h0, 6'd6);
    step(); m_idle(); stall_w = 1'b1;
    vectors++; if (result_w !== 32'h55) begin miscompares++; $display("FAIL stall_result_w: got %h expected 00000055", result_w); end
    step(); exp_instret++;
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL stall_instret_held1: got %0d expected %0d", instret, exp_instret); end
    vectors++; if (reg_write_w !== 1'b1 || rd_w !== 6'd6) begin miscompares++; $display("FAIL stall_hold: got we=%b rd=%0d expected we=1 rd=6", reg_write_w, rd_w); end
    step(); stall_w = 1'b0;
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL stall_instret_held2: got %0d expected %0d", instret, exp_instret); end
    step();
    vectors++; if (reg_write_w !== 1'b0 || instret !== exp_instret) begin miscompares++; $display("FAIL stall_release: got we=%b instret=%0d expected we=0 instret=%0d", reg_write_w, instret, exp_instret); end
  endtask

  task automatic test_rd0_flush();
    m_issue(3'd0, 2'd0, 32'h0000_0077, 32'h0, 6'd0);
    step(); m_idle();
    vectors++; if (reg_write_w !== 1'b0) begin miscompares++; $display("FAIL rd0_reg_write_w: got %b expected 0", reg_write_w); end
    step(); exp_instret++;
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL rd0_instret: got %0d expected %0d", instret, exp_instret); end
    m_issue(3'd0, 2'd0, 32'h0000_0088, 32'h0, 6'd3); flush_w = 1'b1;
    step(); flush_w = 1'b0; m_idle();
    vectors++; if (reg_write_w !== 1'b0) begin miscompares++; $display("FAIL flush_reg_write_w: got %b expected 0", reg_write_w); end
    step();
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL flush_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_in(input int n_wait, input logic [7:0] data, input logic [5:0] rd);
    int stalls = 0, pops = 0, readies = 0, writes = 0;
    logic [31:0] wval = '0;
    logic [5:0]  wrd = '0;
    bit done = 1'b0;
    m_issue(3'd5, 2'd0, 32'h0, 32'h0, rd);
    step();
    for (int c = 0; c < 40 && !done; c++) begin
      in_valid = (c >= n_wait) && (pops == 0);
      in_data = data;
      if (n_wait > 3 && (c == 2 || c == 3)) begin
        m_issue(3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 6'd4); flush_w = 1'b1;
      end else begin
        m_idle(); flush_w = 1'b0;
      end
      #1;
      if (!io_stall && c > 0) done = 1'b1;
      else begin
        if (io_stall) stalls++;
        if (in_ready) readies++;
        if (in_ready && in_valid) pops++;
        if (reg_write_w) begin writes++; wval = result_w; wrd = rd_w; end
        step();
      end
    end
    in_valid = 1'b0;
    exp_instret++;
    vectors++; if (!done) begin miscompares++; $display("FAIL in%0d_timeout: io_stall still %b after 40 cycles", n_wait, io_stall); end
    vectors++; if (stalls !== n_wait + 2) begin miscompares++; $display("FAIL in%0d_stall_cycles: got %0d expected %0d", n_wait, stalls, n_wait + 2); end
    vectors++; if (pops !== 1) begin miscompares++; $display("FAIL in%0d_pops: got %0d expected 1", n_wait, pops); end
    vectors++; if (readies !== n_wait + 1) begin miscompares++; $display("FAIL in%0d_ready_cycles: got %0d expected %0d", n_wait, readies, n_wait + 1); end
    vectors++; if (writes !== 1) begin miscompares++; $display("FAIL in%0d_writes: got %0d expected 1", n_wait, writes); end
    vectors++; if (wval !== {24'h0, data} || wrd !== rd) begin miscompares++; $display("FAIL in%0d_write_data: got %h rd=%0d expected %h rd=%0d", n_wait, wval, wrd, {24'h0, data}, rd); end
    vectors++; if (reg_write_w !== 1'b0) begin miscompares++; $display("FAIL in%0d_post_reg_write_w: got %b expected 0", n_wait, reg_write_w); end
    vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL in%0d_instret: got %0d expected %0d", n_wait, instret, exp_instret); end
  endtask

  task automatic test_reset_mid_in();
    in_valid = 1'b0;
    m_issue(3'd5, 2'd0, 32'h0, 32'h0, 6'd10);
    step(); m_idle(); step(); step();
    vectors++; if (io_stall !== 1'b1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL wait_state: got io_stall=%b in_ready=%b expected 1 1", io_stall, in_ready); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL async_rst_io_stall: got %b expected 0", io_stall); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL async_rst_in_ready: got %b expected 0", in_ready); end
    vectors++; if (instret !== 64'd0) begin miscompares++; $display("FAIL async_rst_instret: got %0d expected 0", instret); end
    exp_instret = '0;
    step(); rst = 1'b0; step();
    test_in(0, 8'h5A, 6'd12);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_result_sel();
    test_load();
    test_stall();
    test_rd0_flush();
    test_in(0, 8'h41, 6'd9);
    test_in(5, 8'h0A, 6'd11);
    test_reset_mid_in();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
